program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/stupid_machine_pkg.sv | 15 +
 rtl/instr_piso.sv | 27 ++
 rtl/program_loader.sv | 99 +++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stupid_machine_pkg.sv
// Shared definitions for the program loader.
// INSTR_W / MAX_INSTR are the default instruction width and program length;
// loader_state_e is the loader FSM state encoding.
package stupid_machine_pkg;
  localparam int INSTR_W   = 13;
  localparam int MAX_INSTR = 5;
  localparam int WCNT_W    = 3;
  localparam int BCNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } loader_state_e;
endpackage

// File: rtl/instr_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears register)
//   load       : capture din (wins over shift)
//   shift      : move register one place toward the MSB, zero fill
//   din        : parallel word
//   msb        : current serial bit
module instr_piso #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/program_loader.sv
// Program loader: accepts instruction words from a host over a valid/ready
// handshake and streams them bit-serially (MSB first) to the processor's
// serial load port.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   instr_in       : instruction word from host
//   instr_valid    : host has a word
//   instr_last     : word is the last of the program
//   instr_ready    : loader takes a word this cycle
//   ser_out/ser_en : serial bit and its enable
//   busy           : FSM not idle
//   done           : one-cycle pulse after the final bit of the program
//   word_count     : words fully shifted in this program
//   overflow       : sticky, host offered a word beyond MAX_INSTR
module program_loader #(
  parameter int INSTR_W   = stupid_machine_pkg::INSTR_W,
  parameter int MAX_INSTR = stupid_machine_pkg::MAX_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               instr_last,
  output logic               instr_ready,
  output logic               ser_out,
  output logic               ser_en,
  output logic               busy,
  output logic               done,
  output logic [2:0]         word_count,
  output logic               overflow
);
  import stupid_machine_pkg::*;

  loader_state_e state, state_nxt;
  logic [BCNT_W-1:0] bit_cnt;
  logic              last_q;
  logic              bit0, room, xfer, piso_msb;

  // Cycle carrying bit 0 of the current word: the only point in SHIFT where
  // a follow-on word may be taken without a gap.
  assign bit0 = (state == SHIFT) && (bit_cnt == '0);
  // Another word still fits after the one being finished.
  assign room = (int'(word_count) + 1) < MAX_INSTR;
  assign xfer = instr_valid && instr_ready;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        instr_ready = bit0 && !last_q && room;
        // A transfer on bit 0 keeps us in SHIFT with the new word loaded.
        if (bit0 && !xfer) state_nxt = (last_q || !room) ? DONE : IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        bit_cnt <= BCNT_W'(INSTR_W - 1);
        last_q  <= instr_last;
      end else if (state == SHIFT && bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (bit0 && int'(word_count) < MAX_INSTR) word_count <= word_count + 3'd1;
      else if (state == DONE)                   word_count <= '0;
      // Ready is held low here only because the program is full.
      if (bit0 && !last_q && !room && instr_valid) overflow <= 1'b1;
    end
  end

  instr_piso #(.W(INSTR_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (xfer),
    .shift ((state == SHIFT) && !xfer),
    .din   (instr_in),
    .msb   (piso_msb)
  );

  assign ser_en  = (state == SHIFT);
  assign ser_out = ser_en && piso_msb;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int W  = 13;
  localparam int MX = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  instr_in = '0;
  logic          instr_valid = 1'b0;
  logic          instr_last = 1'b0;
  logic          instr_ready, ser_out, ser_en, busy, done, overflow;
  logic [2:0]    word_count;

  int n_chk = 0;
  int n_err = 0;

  program_loader dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_last(instr_last), .instr_ready(instr_ready), .ser_out(ser_out),
    .ser_en(ser_en), .busy(busy), .done(done), .word_count(word_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial-side monitor: plays the processor's instruction memory, collecting
  // words from the bit stream, plus ser_en run lengths and done pulses.
  bit [W-1:0] got_q[$];
  bit [W-1:0] exp_q[$];
  int         runs[$];
  bit [W-1:0] cur;
  int nbit, run, cyc, last_en_cyc, done_cyc, done_cnt, wc_at_done, bad_idle;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cur = '0; nbit = 0; run = 0;
    end else begin
      if (ser_en) begin
        cur = {cur[W-2:0], ser_out};
        nbit++; run++; last_en_cyc = cyc;
        if (nbit == W) begin got_q.push_back(cur); nbit = 0; end
      end else begin
        if (ser_out) bad_idle++;
        if (run != 0) begin runs.push_back(run); run = 0; end
      end
      if (done) begin done_cnt++; done_cyc = cyc; wc_at_done = int'(word_count); end
    end
  end

  task automatic clr_mon();
    got_q.delete(); exp_q.delete(); runs.delete();
    done_cnt = 0; wc_at_done = -1; bad_idle = 0; last_en_cyc = 0; done_cyc = 0;
  endtask

  task automatic cyc_wait(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_last = 1'b0;
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(1);
  endtask

  // Offer one word; may_drop lets the offer lapse once the loader reports done.
  task automatic send(input bit [W-1:0] w, input bit last, input bit may_drop, output bit acc);
    acc = 1'b0;
    instr_in = w; instr_valid = 1'b1; instr_last = last;
    for (int i = 0; i < 200; i++) begin
      if (instr_ready) begin @(posedge clk); #1; acc = 1'b1; break; end
      if (may_drop && done) break;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0; instr_last = 1'b0; instr_in = W'($urandom);
    if (!may_drop) chk("xfer_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (i == 200) chk("idle_timeout", 32'(busy), 32'd0);
    cyc_wait(2);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_word"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    chk({tag, "_ser_out_idle"}, 32'(bad_idle), 32'd0);
  endtask

  bit acc;
  bit [W-1:0] w;
  bit [W-1:0] stream[4];

  initial begin
    clr_mon();
    // Reset state while reset is held
    cyc_wait(2);
    chk("rst_ser_en", 32'(ser_en), 0);
    chk("rst_ser_out", 32'(ser_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    cyc_wait(1);
    chk("rst_ready", 32'(instr_ready), 1);

    // Single all-ones word, last
    clr_mon();
    send(13'h1FFF, 1'b1, 1'b0, acc); exp_q.push_back(13'h1FFF);
    wait_idle();
    check_words("single");
    chk("single_runs", 32'(runs.size()), 1);
    chk("single_run_len", runs.size() > 0 ? 32'(runs[0]) : 0, 13);
    chk("single_done_cnt", 32'(done_cnt), 1);
    chk("single_done_lat", 32'(done_cyc - last_en_cyc), 1);
    chk("single_wc", 32'(wc_at_done), 1);
    chk("single_wc_clr", 32'(word_count), 0);

    // Four words back-to-back
    clr_mon();
    stream[0] = 13'h1FFF; stream[1] = 13'h0000;
    stream[2] = 13'b1010101010101; stream[3] = 13'b0101010101010;
    for (int i = 0; i < 4; i++) begin
      send(stream[i], i == 3, 1'b0, acc); exp_q.push_back(stream[i]);
    end
    wait_idle();
    check_words("b2b");
    chk("b2b_runs", 32'(runs.size()), 1);
    chk("b2b_run_len", runs.size() > 0 ? 32'(runs[0]) : 0, 52);
    chk("b2b_done_cnt", 32'(done_cnt), 1);
    chk("b2b_wc", 32'(wc_at_done), 4);
    chk("b2b_ovf", 32'(overflow), 0);

    // Overflow: five non-last words, then a sixth that must be dropped
    clr_mon();
    for (int i = 0; i < MX; i++) begin
      w = W'($urandom); send(w, 1'b0, 1'b0, acc); exp_q.push_back(w);
    end
    send(13'h1ABC, 1'b0, 1'b1, acc);
    chk("ovf_sixth_acc", 32'(acc), 0);
    wait_idle();
    cyc_wait(20);
    check_words("ovf");
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_done_cnt", 32'(done_cnt), 1);
    chk("ovf_wc", 32'(wc_at_done), MX);
    do_reset();
    chk("ovf_rst_clear", 32'(overflow), 0);

    // Reset mid-word, during bit 6
    clr_mon();
    send(13'b1010101010101, 1'b1, 1'b0, acc);
    cyc_wait(6);
    reset = 1'b1;
    cyc_wait(1);
    chk("midrst_ser_en", 32'(ser_en), 0);
    chk("midrst_ser_out", 32'(ser_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wc", 32'(word_count), 0);
    reset = 1'b0;
    cyc_wait(1);
    chk("midrst_ready", 32'(instr_ready), 1);
    cyc_wait(20);
    chk("midrst_words", 32'(got_q.size()), 0);
    chk("midrst_runs", 32'(runs.size()), 0);
    chk("midrst_done", 32'(done_cnt), 0);

    // Gap between words: back through IDLE
    clr_mon();
    send(13'h0F0F, 1'b0, 1'b0, acc); exp_q.push_back(13'h0F0F);
    wait_idle();
    cyc_wait(3);
    chk("gap_wc_idle", 32'(word_count), 1);
    send(13'h1234, 1'b1, 1'b0, acc); exp_q.push_back(13'h1234);
    wait_idle();
    check_words("gap");
    chk("gap_runs", 32'(runs.size()), 2);
    chk("gap_run0", runs.size() > 0 ? 32'(runs[0]) : 0, 13);
    chk("gap_run1", runs.size() > 1 ? 32'(runs[1]) : 0, 13);
    chk("gap_wc", 32'(wc_at_done), 2);
    chk("gap_done_cnt", 32'(done_cnt), 1);

    // Random programs: random length, words and inter-word gaps
    for (int p = 0; p < 10; p++) begin
      int n;
      clr_mon();
      n = int'($urandom_range(1, MX));
      for (int k = 0; k < n; k++) begin
        w = W'($urandom);
        send(w, k == n - 1, 1'b0, acc); exp_q.push_back(w);
        if (k < n - 1 && $urandom_range(0, 1) == 1) cyc_wait(int'($urandom_range(1, 20)));
      end
      wait_idle();
      check_words("rnd");
      chk("rnd_done_cnt", 32'(done_cnt), 1);
      chk("rnd_wc", 32'(wc_at_done), 32'(n));
      chk("rnd_ovf", 32'(overflow), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
